sa_tile_stream_buffer: RTL and testbench
========================================

Name: sa_tile_stream_buffer

Overview:
- Elastic tile buffer on the read path: sits between the read DMA stream output and the systolic engine stream input (s_tdata/s_tvalid/s_tready).
- Absorbs AXI read-burst jitter and engine back-pressure.
- Enforces the per-tile word count: accepts exactly the programmed number of words per tile and marks the last one with m_tlast.
- Reports tile completion to the core FSM.

Parameters:
- DATA_WIDTH, 32, stream word width in bits.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH)+1, width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  tile start pulse. Sampled only in IDLE.
- i_tile_words  in  32  words in this tile. Latched on an accepted i_start.
- s_tdata  in  DATA_WIDTH  upstream (read DMA) data.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  upstream ready.
- m_tdata  out  DATA_WIDTH  downstream (engine) data.
- m_tvalid  out  1  downstream valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high with the final word of the tile.
- o_level  out  LVL_W  current FIFO occupancy.
- o_busy  out  1  tile in progress.
- o_tile_done  out  1  one-cycle pulse when the tile completes.
- o_error  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous, rst=1): state=IDLE; pointers, counters and occupancy cleared; FIFO contents discarded.
  - Output values: s_tready=0, m_tvalid=0, m_tlast=0, o_level=0, o_busy=0, o_tile_done=0, o_error=0, m_tdata=don't-care.
  - Reset mid-tile aborts the tile silently: no o_tile_done pulse.
- States: IDLE, ACTIVE (input words still owed), DRAIN (all input accepted, FIFO emptying).
- IDLE, i_start=1, i_tile_words>0:
  - latch tile_words; clear in_cnt and out_cnt; clear o_error; go to ACTIVE; o_busy=1 from the next cycle.
- IDLE, i_start=1, i_tile_words==0:
  - o_tile_done pulses the next cycle; state stays IDLE; no transfers; not an error.
- i_start while not IDLE: ignored; o_error set to 1 (sticky until the next accepted i_start or rst).
- Input side:
  - s_tready = (state==ACTIVE) && (occupancy<DEPTH). Combinational from registered state only; never depends on s_tvalid.
  - push = s_tvalid && s_tready; in_cnt increments on push.
  - On the push where in_cnt == tile_words-1, go to DRAIN.
  - s_tvalid outside ACTIVE is ignored: data dropped, no error.
- Output side:
  - FIFO is first-word-fall-through: m_tvalid = (occupancy!=0) and m_tdata = mem[rd_ptr].
  - A word pushed in cycle N is visible at the output in cycle N+1 (latency 1).
  - pop = m_tvalid && m_tready; out_cnt increments on pop.
  - m_tlast = m_tvalid && (out_cnt == tile_words-1).
  - Data is held stable while m_tvalid=1 and m_tready=0.
- Simultaneous push and pop: occupancy unchanged; both pointers advance. Sustained throughput is 1 word/cycle.
- Full (occupancy==DEPTH): s_tready=0. A pop in the same cycle does not enable a push; the push waits one cycle.
- Empty: m_tvalid=0 and m_tlast=0. An empty FIFO never pops.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is LVL_W bits (0..DEPTH) and drives o_level directly.
- Tile completion: on the pop with m_tlast=1:
  - next cycle: o_tile_done=1 for exactly 1 cycle, state=IDLE, o_busy=0.
  - i_start in the same cycle as that pulse is accepted (back-to-back tiles).
- Counters are 32-bit with no wrap; tile_words up to 2^32-1 is legal.

Test Plan:
- Basic tile: i_tile_words=8, s_tvalid and m_tready held high, data 0x100..0x107 -> 8 pops in 8 consecutive cycles starting 1 cycle after the first push; m_tlast only with 0x107; o_tile_done pulses 1 cycle after that pop; o_busy falls.
- Back-pressure / full: i_tile_words=40, DEPTH=16, m_tready=0 -> s_tready drops after 16 pushes; o_level=16. Release m_tready -> all 40 words emerge in order, no loss or duplication; o_level returns to 0.
- Random stall: i_tile_words=100, random s_tvalid and m_tready -> output sequence equals input sequence; exactly one m_tlast, on word 100; s_tready=0 after the 100th push even with s_tvalid=1.
- Zero length and back-to-back: i_tile_words=0 -> o_tile_done 1 cycle later with no transfers. Then tile of 4 immediately followed by i_start (tile of 3) in the done cycle -> second tile accepted; 3 words with m_tlast on word 3.
- Protocol error: i_start during ACTIVE -> o_error=1 and stays 1; the current tile completes normally; the next accepted i_start clears o_error.
- Reset mid-tile: rst=1 after 5 of 10 words -> next cycle all outputs are at reset values and no o_tile_done. A new tile of 2 then runs cleanly with no stale data.

Source files
------------

// File: rtl/sa_tile_stream_buffer.sv
// Elastic first-word-fall-through tile buffer between the read DMA stream and the systolic engine.
// Accepts exactly the programmed number of words per tile, tags the last one and reports completion.
module sa_tile_stream_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int LVL_W      = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [31:0]           i_tile_words,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [LVL_W-1:0]      o_level,
   output logic                  o_busy,
   output logic                  o_tile_done,
   output logic                  o_error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
   localparam logic [LVL_W-1:0] ZERO_LVL = LVL_W'(0);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
   localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [LVL_W-1:0]      count_r;
   logic [31:0]           tile_words_r;
   logic [31:0]           in_cnt_r;
   logic [31:0]           out_cnt_r;
   logic                  done_r;
   logic                  done_next_s;
   logic                  error_r;
   logic                  error_next_s;
   logic                  start_ok_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  last_in_s;

   // s_tready looks only at registered state so it never waits on s_tvalid.
   assign s_tready    = (state_r == ACTIVE) && (count_r != FULL_LVL);
   assign push_s      = s_tvalid && s_tready;
   assign m_tvalid    = (count_r != ZERO_LVL);
   assign pop_s       = m_tvalid && m_tready;
   assign m_tdata     = mem_r[rd_ptr_r];
   assign m_tlast     = m_tvalid && (out_cnt_r == (tile_words_r - 32'd1));
   assign last_in_s   = (in_cnt_r == (tile_words_r - 32'd1));
   assign o_level     = count_r;
   assign o_busy      = (state_r != IDLE);
   assign o_tile_done = done_r;
   assign o_error     = error_r;

   // Next-state, completion pulse and sticky error decode.
   always_comb begin
      state_next_s = state_r;
      done_next_s  = 1'b0;
      error_next_s = error_r;
      start_ok_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_start) begin
               error_next_s = 1'b0;
               if (i_tile_words != 32'd0) begin
                  start_ok_s   = 1'b1;
                  state_next_s = ACTIVE;
               end else begin
                  done_next_s  = 1'b1;
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         ACTIVE: begin
            if (i_start) begin
               error_next_s = 1'b1;
            end else begin
               error_next_s = error_r;
            end
            if (push_s && last_in_s) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = ACTIVE;
            end
         end
         DRAIN: begin
            if (i_start) begin
               error_next_s = 1'b1;
            end else begin
               error_next_s = error_r;
            end
            if (pop_s && m_tlast) begin
               state_next_s = IDLE;
               done_next_s  = 1'b1;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state, completion pulse and error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         done_r  <= done_next_s;
         error_r <= error_next_s;
      end
   end

   // Tile length latch and per-tile input/output word counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         tile_words_r <= 32'd0;
         in_cnt_r     <= 32'd0;
         out_cnt_r    <= 32'd0;
      end else if (start_ok_s) begin
         tile_words_r <= i_tile_words;
         in_cnt_r     <= 32'd0;
         out_cnt_r    <= 32'd0;
      end else begin
         if (push_s) begin
            in_cnt_r <= in_cnt_r + 32'd1;
         end
         if (pop_s) begin
            out_cnt_r <= out_cnt_r + 32'd1;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= ZERO_PTR;
         rd_ptr_r <= ZERO_PTR;
         count_r  <= ZERO_LVL;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_LVL;
            2'b01:   count_r <= count_r - ONE_LVL;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= s_tdata;
      end
   end

endmodule

// File: tb/tb_sa_tile_stream_buffer.sv
// Directed bench for sa_tile_stream_buffer: each scenario task drives the stream and checks
// observed pops, tlast placement, occupancy and status flags against hand-computed values.
module tb_sa_tile_stream_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [31:0] i_tile_words;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [4:0]  o_level;
   logic        o_busy;
   logic        o_tile_done;
   logic        o_error;

   int checks = 0;
   int failures = 0;

   logic [31:0] pop_q[$];
   bit          last_q[$];
   int          pop_cyc_q[$];
   int          npush;
   int          first_push_cyc;

   sa_tile_stream_buffer dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_tile_words(i_tile_words),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .o_level(o_level), .o_busy(o_busy), .o_tile_done(o_tile_done), .o_error(o_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock: apply inputs, observe handshakes mid-cycle, then cross the edge.
   task automatic cycle(input logic tv, input logic [31:0] td, input logic tr,
                        output bit pushed, output bit popped, output logic [31:0] pd, output bit pl);
      s_tvalid = tv;
      s_tdata  = td;
      m_tready = tr;
      #1;
      pushed = tv && s_tready;
      popped = m_tvalid && tr;
      pd     = m_tdata;
      pl     = m_tlast;
      tick();
   endtask

   task automatic clear_sb();
      pop_q.delete();
      last_q.delete();
      pop_cyc_q.delete();
      npush = 0;
      first_push_cyc = -1;
   endtask

   task automatic start(input logic [31:0] w);
      i_start      = 1'b1;
      i_tile_words = w;
      tick();
      i_start      = 1'b0;
      i_tile_words = 32'd0;
   endtask

   // rmode: 0 ready high, 1 random, 2 ready low. vmode: 0 valid high, 1 random.
   task automatic stream(input logic [31:0] base, input int vmode, input int rmode,
                         input int maxcyc, output bit got_last);
      bit pu, po, pl;
      logic [31:0] pd;
      logic tv, tr;
      got_last = 1'b0;
      for (int c = 0; c < maxcyc && !got_last; c++) begin
         tv = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         tr = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         cycle(tv, base + 32'(npush), tr, pu, po, pd, pl);
         if (pu) begin
            if (npush == 0) first_push_cyc = c;
            npush++;
         end
         if (po) begin
            pop_q.push_back(pd);
            last_q.push_back(pl);
            pop_cyc_q.push_back(c);
            if (pl) got_last = 1'b1;
         end
      end
      s_tvalid = 1'b0;
      m_tready = 1'b0;
   endtask

   task automatic test_reset();
      bit pu, po, pl;
      logic [31:0] pd;
      rst = 1'b1;
      cycle(1'b1, 32'hDEAD, 1'b1, pu, po, pd, pl);
      cycle(1'b1, 32'hDEAD, 1'b1, pu, po, pd, pl);
      #1;
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
      checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_side got=%b%b exp=00", m_tvalid, m_tlast); end
      checks++; if (o_level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", o_level); end
      checks++; if ({o_busy, o_tile_done, o_error} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {o_busy, o_tile_done, o_error}); end
      rst = 1'b0;
      cycle(1'b1, 32'hBEEF, 1'b1, pu, po, pd, pl);
      checks++; if (pu || o_level !== 5'd0) begin failures++; $display("FAIL idle_drop got=%0b/%0d exp=0/0", pu, o_level); end
   endtask

   task automatic test_basic();
      bit gl;
      clear_sb();
      start(32'd8);
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", o_busy); end
      stream(32'h100, 0, 0, 30, gl);
      checks++; if (!gl || o_tile_done !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL basic_done got=%0b/%b/%b exp=1/1/0", gl, o_tile_done, o_busy); end
      checks++; if (pop_q.size() != 8 || npush != 8) begin failures++; $display("FAIL basic_count got=%0d/%0d exp=8/8", pop_q.size(), npush); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h100 + 32'(k) || last_q[k] !== (k == 7) || pop_cyc_q[k] != first_push_cyc + 1 + k) begin
            failures++;
            $display("FAIL basic_word[%0d] got=%h/%0b/c%0d exp=%h/%0b/c%0d", k, pop_q[k], last_q[k], pop_cyc_q[k],
                     32'h100 + 32'(k), (k == 7), first_push_cyc + 1 + k);
         end
      end
      tick();
      checks++; if (o_tile_done !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", o_tile_done); end
   endtask

   task automatic test_backpressure();
      bit gl;
      clear_sb();
      start(32'd40);
      stream(32'h2000, 0, 2, 25, gl);
      checks++; if (npush != 16 || pop_q.size() != 0) begin failures++; $display("FAIL bp_fill got=%0d/%0d exp=16/0", npush, pop_q.size()); end
      checks++; if (o_level !== 5'd16 || s_tready !== 1'b0 || m_tvalid !== 1'b1) begin failures++; $display("FAIL bp_full got=%0d/%b/%b exp=16/0/1", o_level, s_tready, m_tvalid); end
      stream(32'h2000, 0, 0, 100, gl);
      checks++; if (!gl || o_tile_done !== 1'b1 || o_level !== 5'd0) begin failures++; $display("FAIL bp_done got=%0b/%b/%0d exp=1/1/0", gl, o_tile_done, o_level); end
      checks++; if (pop_q.size() != 40 || npush != 40) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=40/40", pop_q.size(), npush); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h2000 + 32'(k) || last_q[k] !== (k == 39)) begin
            failures++; $display("FAIL bp_word[%0d] got=%h/%0b exp=%h/%0b", k, pop_q[k], last_q[k], 32'h2000 + 32'(k), (k == 39));
         end
      end
   endtask

   task automatic test_random();
      bit gl;
      clear_sb();
      start(32'd100);
      stream(32'h5000, 1, 1, 2000, gl);
      checks++; if (!gl || o_tile_done !== 1'b1) begin failures++; $display("FAIL rnd_done got=%0b/%b exp=1/1", gl, o_tile_done); end
      checks++; if (pop_q.size() != 100 || npush != 100) begin failures++; $display("FAIL rnd_count got=%0d/%0d exp=100/100", pop_q.size(), npush); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h5000 + 32'(k) || last_q[k] !== (k == 99)) begin
            failures++; $display("FAIL rnd_word[%0d] got=%h/%0b exp=%h/%0b", k, pop_q[k], last_q[k], 32'h5000 + 32'(k), (k == 99));
         end
      end
   endtask

   task automatic test_zero_back_to_back();
      bit gl;
      clear_sb();
      start(32'd0);
      checks++; if (o_tile_done !== 1'b1 || o_busy !== 1'b0 || o_level !== 5'd0) begin failures++; $display("FAIL zero_done got=%b/%b/%0d exp=1/0/0", o_tile_done, o_busy, o_level); end
      stream(32'h900, 0, 0, 3, gl);
      checks++; if (npush != 0 || pop_q.size() != 0 || o_error !== 1'b0) begin failures++; $display("FAIL zero_idle got=%0d/%0d/%b exp=0/0/0", npush, pop_q.size(), o_error); end
      start(32'd4);
      stream(32'h200, 0, 0, 20, gl);
      checks++; if (!gl || o_tile_done !== 1'b1 || pop_q.size() != 4) begin failures++; $display("FAIL b2b_first got=%0b/%b/%0d exp=1/1/4", gl, o_tile_done, pop_q.size()); end
      clear_sb();
      start(32'd3);
      checks++; if (o_busy !== 1'b1 || o_error !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b/%b exp=1/0", o_busy, o_error); end
      stream(32'h300, 0, 0, 20, gl);
      checks++; if (!gl || pop_q.size() != 3) begin failures++; $display("FAIL b2b_second got=%0b/%0d exp=1/3", gl, pop_q.size()); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h300 + 32'(k) || last_q[k] !== (k == 2)) begin
            failures++; $display("FAIL b2b_word[%0d] got=%h/%0b exp=%h/%0b", k, pop_q[k], last_q[k], 32'h300 + 32'(k), (k == 2));
         end
      end
   endtask

   task automatic test_protocol_error();
      bit gl;
      clear_sb();
      start(32'd6);
      stream(32'h400, 0, 0, 3, gl);
      start(32'd5);
      checks++; if (o_error !== 1'b1 || o_busy !== 1'b1) begin failures++; $display("FAIL err_set got=%b/%b exp=1/1", o_error, o_busy); end
      stream(32'h400, 0, 0, 30, gl);
      checks++; if (!gl || o_tile_done !== 1'b1 || o_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b/%b/%b exp=1/1/1", gl, o_tile_done, o_error); end
      checks++; if (pop_q.size() != 6 || npush != 6) begin failures++; $display("FAIL err_count got=%0d/%0d exp=6/6", pop_q.size(), npush); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h400 + 32'(k) || last_q[k] !== (k == 5)) begin
            failures++; $display("FAIL err_word[%0d] got=%h/%0b exp=%h/%0b", k, pop_q[k], last_q[k], 32'h400 + 32'(k), (k == 5));
         end
      end
      clear_sb();
      start(32'd2);
      checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", o_error); end
      stream(32'h480, 0, 0, 20, gl);
      checks++; if (!gl || pop_q.size() != 2) begin failures++; $display("FAIL err_next_tile got=%0b/%0d exp=1/2", gl, pop_q.size()); end
   endtask

   task automatic test_reset_mid_tile();
      bit gl, pu, po, pl;
      logic [31:0] pd;
      clear_sb();
      start(32'd10);
      stream(32'h600, 0, 2, 5, gl);
      checks++; if (npush != 5 || o_level !== 5'd5) begin failures++; $display("FAIL mid_fill got=%0d/%0d exp=5/5", npush, o_level); end
      rst = 1'b1;
      cycle(1'b0, 32'd0, 1'b0, pu, po, pd, pl);
      rst = 1'b0;
      #1;
      checks++; if ({s_tready, m_tvalid, m_tlast} !== 3'b000 || o_level !== 5'd0) begin failures++; $display("FAIL mid_rst_stream got=%b/%0d exp=000/0", {s_tready, m_tvalid, m_tlast}, o_level); end
      checks++; if ({o_busy, o_tile_done, o_error} !== 3'b000) begin failures++; $display("FAIL mid_rst_status got=%b exp=000", {o_busy, o_tile_done, o_error}); end
      tick();
      checks++; if (o_tile_done !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", o_tile_done); end
      clear_sb();
      start(32'd2);
      stream(32'h700, 0, 0, 20, gl);
      checks++; if (!gl || pop_q.size() != 2 || o_tile_done !== 1'b1) begin failures++; $display("FAIL mid_new_tile got=%0b/%0d/%b exp=1/2/1", gl, pop_q.size(), o_tile_done); end
      for (int k = 0; k < pop_q.size(); k++) begin
         checks++;
         if (pop_q[k] !== 32'h700 + 32'(k) || last_q[k] !== (k == 1)) begin
            failures++; $display("FAIL mid_word[%0d] got=%h/%0b exp=%h/%0b", k, pop_q[k], last_q[k], 32'h700 + 32'(k), (k == 1));
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      i_start      = 1'b0;
      i_tile_words = 32'd0;
      s_tdata      = 32'd0;
      s_tvalid     = 1'b0;
      m_tready     = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_zero_back_to_back();
      test_protocol_error();
      test_reset_mid_tile();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
